// File: rtl/coord_scan_ctrl_if.sv
// -----------------------------------------------------------------------------
// coord_scan_ctrl_if
// Bundle of the control, coordinate-write and presentation signals of the
// block-scan controller.
//
//   slave  modport : the controller (coord_scan_ctrl)
//   master modport : whoever drives the scan request and consumes coordinates
//
// Signals
//   START, ABORT          scan request / cancel
//   BASE_X, BASE_Y        block origin, 8-bit two's complement
//   BLK_W, BLK_H          block width-1 / height-1 (CNT_W bits)
//   X_WE, Y_WE            write enables for the external coordinate registers
//   X_DATA, Y_DATA        data for those registers, 8-bit two's complement
//   COORD_VALID, LAST     registers hold the current position / final position
//   COORD_READY           downstream acceptance
//   BUSY, DONE            scan in progress / one-cycle completion pulse
//
// Handshake: a position is transferred on every rising CLK edge where
// COORD_VALID and COORD_READY are both 1. Once COORD_VALID is raised it stays
// high, with X_DATA/Y_DATA/LAST unchanged, until that edge (ABORT and reset
// excepted). COORD_READY may change freely and has no effect while
// COORD_VALID is 0.
// -----------------------------------------------------------------------------
interface coord_scan_ctrl_if #(
    parameter int CNT_W = 4
);
    logic             START;
    logic             ABORT;
    logic [7:0]       BASE_X;
    logic [7:0]       BASE_Y;
    logic [CNT_W-1:0] BLK_W;
    logic [CNT_W-1:0] BLK_H;
    logic             X_WE;
    logic             Y_WE;
    logic [7:0]       X_DATA;
    logic [7:0]       Y_DATA;
    logic             COORD_VALID;
    logic             COORD_READY;
    logic             LAST;
    logic             BUSY;
    logic             DONE;

    modport slave (
        input  START, ABORT, BASE_X, BASE_Y, BLK_W, BLK_H, COORD_READY,
        output X_WE, Y_WE, X_DATA, Y_DATA, COORD_VALID, LAST, BUSY, DONE
    );

    modport master (
        output START, ABORT, BASE_X, BASE_Y, BLK_W, BLK_H, COORD_READY,
        input  X_WE, Y_WE, X_DATA, Y_DATA, COORD_VALID, LAST, BUSY, DONE
    );
endinterface

// File: rtl/coord_scan_ctrl.sv
// -----------------------------------------------------------------------------
// coord_scan_ctrl
// Raster-scans a (BLK_W+1) x (BLK_H+1) block starting at (BASE_X, BASE_Y).
// For every position it writes X (and Y on the first position and each row
// change) into external coordinate registers, then presents the position
// with COORD_VALID until the downstream interpolator accepts it.
//
// Ports
//   CLK          clock, rising edge
//   RST_ASYNC_N  asynchronous active-low reset
//   bus          coord_scan_ctrl_if.slave (see interface for signal list)
//   state_dbg_o  current FSM state (IDLE=0, WRITE=1, PRESENT=2, FINISH=3)
//
// All outputs are registers. Coordinates wrap modulo 256.
// -----------------------------------------------------------------------------
module coord_scan_ctrl #(
    parameter int CNT_W = 4
) (
    input  logic             CLK,
    input  logic             RST_ASYNC_N,
    coord_scan_ctrl_if.slave bus,
    output logic [1:0]       state_dbg_o
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WRITE   = 2'd1,
        PRESENT = 2'd2,
        FINISH  = 2'd3
    } state_t;

    state_t           state_q;
    logic [7:0]       base_x_q, base_y_q;
    logic [CNT_W-1:0] blk_w_q, blk_h_q;
    logic [CNT_W-1:0] col_q, row_q;
    logic             x_we_q, y_we_q;
    logic [7:0]       x_data_q, y_data_q;
    logic             valid_q, last_q, busy_q, done_q;

    logic [CNT_W-1:0] col_inc_d, row_inc_d;
    logic             last_pos_d;

    assign col_inc_d  = col_q + CNT_W'(1);
    assign row_inc_d  = row_q + CNT_W'(1);
    assign last_pos_d = (col_q == blk_w_q) && (row_q == blk_h_q);

    // 8-bit two's-complement add, wraps modulo 256.
    function automatic logic [7:0] add8(input logic [7:0] base, input logic [CNT_W-1:0] ofs);
        return base + 8'(ofs);
    endfunction

    always_ff @(posedge CLK or negedge RST_ASYNC_N) begin
        if (!RST_ASYNC_N) begin
            state_q  <= IDLE;
            base_x_q <= '0;
            base_y_q <= '0;
            blk_w_q  <= '0;
            blk_h_q  <= '0;
            col_q    <= '0;
            row_q    <= '0;
            x_we_q   <= 1'b0;
            y_we_q   <= 1'b0;
            x_data_q <= '0;
            y_data_q <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else if (bus.ABORT) begin
            // Abort wins over START and over a pending handshake.
            state_q <= IDLE;
            x_we_q  <= 1'b0;
            y_we_q  <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.START) begin
                        base_x_q <= bus.BASE_X;
                        base_y_q <= bus.BASE_Y;
                        blk_w_q  <= bus.BLK_W;
                        blk_h_q  <= bus.BLK_H;
                        col_q    <= '0;
                        row_q    <= '0;
                        // First position: both registers written, offset 0.
                        x_we_q   <= 1'b1;
                        y_we_q   <= 1'b1;
                        x_data_q <= bus.BASE_X;
                        y_data_q <= bus.BASE_Y;
                        busy_q   <= 1'b1;
                        state_q  <= WRITE;
                    end
                end
                WRITE: begin
                    x_we_q  <= 1'b0;
                    y_we_q  <= 1'b0;
                    valid_q <= 1'b1;
                    last_q  <= last_pos_d;
                    state_q <= PRESENT;
                end
                PRESENT: begin
                    if (bus.COORD_READY) begin
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                        if (col_q < blk_w_q) begin
                            col_q    <= col_inc_d;
                            x_we_q   <= 1'b1;
                            x_data_q <= add8(base_x_q, col_inc_d);
                            state_q  <= WRITE;
                        end else if (row_q < blk_h_q) begin
                            col_q    <= '0;
                            row_q    <= row_inc_d;
                            x_we_q   <= 1'b1;
                            y_we_q   <= 1'b1;
                            x_data_q <= base_x_q;
                            y_data_q <= add8(base_y_q, row_inc_d);
                            state_q  <= WRITE;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= FINISH;
                        end
                    end
                end
                FINISH: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.X_WE        = x_we_q;
    assign bus.Y_WE        = y_we_q;
    assign bus.X_DATA      = x_data_q;
    assign bus.Y_DATA      = y_data_q;
    assign bus.COORD_VALID = valid_q;
    assign bus.LAST        = last_q;
    assign bus.BUSY        = busy_q;
    assign bus.DONE        = done_q;
    assign state_dbg_o     = state_q;
endmodule

// File: tb/tb_coord_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_coord_scan_ctrl
// Directed + randomized bench for coord_scan_ctrl. The expected position list
// of each block is built from the raster rule (row-major, x = BASE_X + col,
// y = BASE_Y + row, mod 256) and checked against the DUT cycle by cycle.
// -----------------------------------------------------------------------------
module tb_coord_scan_ctrl;
    localparam int CNT_W = 4;

    logic       CLK = 1'b0;
    logic       RST_ASYNC_N = 1'b0;
    logic [1:0] state_dbg;
    int         checks = 0;
    int         errors = 0;
    int         dc;
    logic [7:0] seen_x[$];

    typedef struct {
        logic [7:0] x;
        logic [7:0] y;
        bit         yw;
        bit         last;
    } pos_t;

    coord_scan_ctrl_if #(.CNT_W(CNT_W)) bus();

    coord_scan_ctrl #(.CNT_W(CNT_W)) dut (
        .CLK        (CLK),
        .RST_ASYNC_N(RST_ASYNC_N),
        .bus        (bus),
        .state_dbg_o(state_dbg)
    );

    // ---------------- clock ----------------
    always #5 CLK = ~CLK;

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_x_we"},  bus.X_WE, 0);
        check({tag, "_y_we"},  bus.Y_WE, 0);
        check({tag, "_x_data"}, bus.X_DATA, 0);
        check({tag, "_y_data"}, bus.Y_DATA, 0);
        check({tag, "_valid"}, bus.COORD_VALID, 0);
        check({tag, "_last"},  bus.LAST, 0);
        check({tag, "_busy"},  bus.BUSY, 0);
        check({tag, "_done"},  bus.DONE, 0);
    endtask

    // Runs one block. ready_pct: chance READY is high in a PRESENT cycle.
    // hold: READY forced low for this many PRESENT cycles first.
    // abort_idx: position index at which ABORT is raised (-1: none).
    // done_cyc: cycle DONE was seen, counted from the edge that samples START.
    task automatic run_block(input logic [7:0] bx, input logic [7:0] by,
                             input int w, input int h, input int ready_pct,
                             input int hold, input int abort_idx,
                             output int done_cyc);
        pos_t       exp_q[$];
        pos_t       e;
        int         phase;   // 0: expect write, 1: expect present, 2: expect done
        int         cyc;
        int         idx;
        int         ycnt;
        bit         fin;
        bit         rdy;
        logic [7:0] cur_x;
        logic [7:0] cur_y;
        bit         cur_last;

        done_cyc = -1;
        idx = 0;
        ycnt = 0;
        fin = 1'b0;
        cur_x = '0;
        cur_y = '0;
        cur_last = 1'b0;
        seen_x.delete();
        for (int r = 0; r <= h; r++) begin
            for (int c = 0; c <= w; c++) begin
                e.x    = bx + 8'(c);
                e.y    = by + 8'(r);
                e.yw   = (c == 0);
                e.last = (c == w) && (r == h);
                exp_q.push_back(e);
            end
        end

        bus.BASE_X      = bx;
        bus.BASE_Y      = by;
        bus.BLK_W       = CNT_W'(w);
        bus.BLK_H       = CNT_W'(h);
        bus.ABORT       = 1'b0;
        bus.COORD_READY = 1'b0;
        bus.START       = 1'b1;
        tick();
        cyc = 1;
        phase = 0;
        // Block inputs are scrambled after capture; they must not matter.
        bus.BASE_X = 8'($urandom);
        bus.BASE_Y = 8'($urandom);
        bus.BLK_W  = CNT_W'($urandom);
        bus.BLK_H  = CNT_W'($urandom);

        while (!fin && cyc < 600) begin
            case (phase)
                0: begin
                    bus.START = 1'($urandom_range(0, 1));
                    check("write_x_we", bus.X_WE, 1);
                    check("write_valid", bus.COORD_VALID, 0);
                    check("write_busy", bus.BUSY, 1);
                    e = exp_q.pop_front();
                    seen_x.push_back(bus.X_DATA);
                    check("write_x_data", bus.X_DATA, e.x);
                    check("write_y_we", bus.Y_WE, e.yw);
                    if (e.yw) check("write_y_data", bus.Y_DATA, e.y);
                    if (bus.Y_WE) ycnt++;
                    cur_x = e.x;
                    if (e.yw) cur_y = e.y;
                    cur_last = e.last;
                    phase = 1;
                end
                1: begin
                    bus.START = 1'($urandom_range(0, 1));
                    check("pres_valid", bus.COORD_VALID, 1);
                    check("pres_x_we", bus.X_WE, 0);
                    check("pres_y_we", bus.Y_WE, 0);
                    check("pres_last", bus.LAST, cur_last);
                    check("pres_x_stable", bus.X_DATA, cur_x);
                    check("pres_y_stable", bus.Y_DATA, cur_y);
                    check("pres_done", bus.DONE, 0);
                    if (idx == abort_idx) begin
                        bus.ABORT = 1'b1;
                        bus.COORD_READY = 1'b1;
                        bus.START = 1'b1;
                        tick();
                        bus.ABORT = 1'b0;
                        bus.START = 1'b0;
                        bus.COORD_READY = 1'b0;
                        check("abort_busy", bus.BUSY, 0);
                        check("abort_valid", bus.COORD_VALID, 0);
                        check("abort_x_we", bus.X_WE, 0);
                        check("abort_done", bus.DONE, 0);
                        for (int k = 0; k < 3; k++) begin
                            tick();
                            check("abort_no_done", bus.DONE, 0);
                            check("abort_idle_busy", bus.BUSY, 0);
                        end
                        fin = 1'b1;
                    end else begin
                        if (hold > 0) begin
                            rdy = 1'b0;
                            hold--;
                        end else begin
                            rdy = ($urandom_range(0, 99) < ready_pct);
                        end
                        bus.COORD_READY = rdy;
                        if (rdy) begin
                            idx++;
                            phase = cur_last ? 2 : 0;
                        end
                    end
                end
                default: begin
                    check("finish_done", bus.DONE, 1);
                    check("finish_valid", bus.COORD_VALID, 0);
                    check("finish_x_we", bus.X_WE, 0);
                    done_cyc = cyc;
                    bus.COORD_READY = 1'b0;
                    // START in the FINISH cycle must be ignored.
                    bus.START = 1'b1;
                    tick();
                    bus.START = 1'b0;
                    check("done_single_pulse", bus.DONE, 0);
                    check("after_done_busy", bus.BUSY, 0);
                    check("after_done_x_we", bus.X_WE, 0);
                    fin = 1'b1;
                end
            endcase
            if (!fin) begin
                tick();
                cyc++;
            end
        end
        bus.START = 1'b0;
        check("block_finished", fin, 1);
        if (abort_idx < 0) begin
            check("positions_remaining", exp_q.size(), 0);
            check("y_we_count", ycnt, h + 1);
            check("done_seen", (done_cyc >= 0), 1);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        bus.START = 1'b0;
        bus.ABORT = 1'b0;
        bus.BASE_X = '0;
        bus.BASE_Y = '0;
        bus.BLK_W = '0;
        bus.BLK_H = '0;
        bus.COORD_READY = 1'b0;

        // Reset state
        repeat (2) tick();
        check_all_zero("reset");
        #2 RST_ASYNC_N = 1'b1;
        tick();
        check_all_zero("post_reset");

        // ABORT overrides START in IDLE
        bus.START = 1'b1;
        bus.ABORT = 1'b1;
        tick();
        bus.START = 1'b0;
        bus.ABORT = 1'b0;
        check("idle_abort_busy", bus.BUSY, 0);
        check("idle_abort_x_we", bus.X_WE, 0);

        // Single position at (3,-2)
        run_block(8'd3, 8'hFE, 0, 0, 100, 0, -1, dc);
        check("single_done_cycle", dc, 3);

        // 2x2 raster, READY tied high
        run_block(8'd0, 8'd0, 1, 1, 100, 0, -1, dc);
        check("raster_done_cycle", dc, 9);

        // X wrap 126, 127, -128, -127
        run_block(8'd126, 8'h10, 3, 0, 100, 0, -1, dc);
        check("wrap_len", seen_x.size(), 4);
        check("wrap_x0", seen_x[0], 8'h7E);
        check("wrap_x1", seen_x[1], 8'h7F);
        check("wrap_x2", seen_x[2], 8'h80);
        check("wrap_x3", seen_x[3], 8'h81);

        // Backpressure: READY low 5 cycles in the first PRESENT; Y wraps too
        run_block(8'hF0, 8'h7F, 2, 1, 100, 5, -1, dc);
        check("backpressure_done_cycle", dc, 2 * 6 + 1 + 5);

        // ABORT during PRESENT of 3rd position of a 4x4 block, then a full block
        run_block(8'd10, 8'd20, 3, 3, 70, 0, 2, dc);
        run_block(8'hC8, 8'h05, 3, 3, 100, 0, -1, dc);
        check("post_abort_done_cycle", dc, 2 * 16 + 1);

        // Reset pulse mid-scan
        bus.BASE_X = 8'd40;
        bus.BASE_Y = 8'd50;
        bus.BLK_W = CNT_W'(3);
        bus.BLK_H = CNT_W'(3);
        bus.COORD_READY = 1'b1;
        bus.START = 1'b1;
        tick();
        bus.START = 1'b0;
        repeat (4) tick();
        #2 RST_ASYNC_N = 1'b0;
        #1;
        check_all_zero("mid_reset");
        tick();
        check_all_zero("mid_reset_hold");
        bus.COORD_READY = 1'b0;
        #2 RST_ASYNC_N = 1'b1;
        tick();
        check("after_reset_done", bus.DONE, 0);
        run_block(8'd5, 8'hFB, 2, 2, 100, 0, -1, dc);
        check("after_reset_done_cycle", dc, 2 * 9 + 1);

        // Randomized blocks with random backpressure
        for (int i = 0; i < 8; i++) begin
            run_block(8'($urandom), 8'($urandom), $urandom_range(0, 5),
                      $urandom_range(0, 4), $urandom_range(30, 100),
                      $urandom_range(0, 3), -1, dc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
